// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults and decode types for the UART receive buffer.
// The transmit-side buffer imports the same package so widths stay in lockstep.
package uart_rx_fifo_pkg;

  localparam int DBIT_DEF   = 8;
  localparam int AWIDTH_DEF = 4;

  // Per-cycle request decode, encoded as {wr, rd}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO between the UART receiver and the host side.
// Bytes pushed while full are dropped and latched in a sticky overflow flag.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              rd,
  output logic [DBIT-1:0]   r_data,
  output logic              empty,
  output logic              full,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] FULL_COUNT = {1'b1, {AWIDTH{1'b0}}};

  // Handshake: wr and rd are single-cycle strobes with no back-pressure.
  // wr is taken when not full (or when full with a simultaneous rd), else
  // the byte is dropped and overflow is set; rd pops r_data when not empty
  // and is silently ignored when empty.

  logic [DBIT-1:0]   mem [DEPTH];
  logic [AWIDTH-1:0] w_ptr, r_ptr;
  logic [AWIDTH:0]   count_q, count_next;
  logic              empty_q, full_q, ovf_q;
  logic              empty_next, full_next, ovf_next;
  logic              do_wr, do_rd, drop;
  fifo_op_e          op;

  always_comb begin
    op    = fifo_op_e'({wr, rd});
    do_wr = 1'b0;
    do_rd = 1'b0;
    drop  = 1'b0;
    unique case (op)
      OP_IDLE: ;
      OP_WRITE: begin
        do_wr = !full_q;
        drop  = full_q;
      end
      OP_READ: do_rd = !empty_q;
      OP_BOTH: begin
        // Empty: write only. Full: the pop frees the slot the push takes.
        do_wr = 1'b1;
        do_rd = !empty_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    count_next = count_q;
    unique case ({do_wr, do_rd})
      2'b10:   count_next = count_q + (AWIDTH+1)'(1);
      2'b01:   count_next = count_q - (AWIDTH+1)'(1);
      default: count_next = count_q;
    endcase
    full_next  = (count_next == FULL_COUNT);
    empty_next = (count_next == '0);
    ovf_next   = ovf_q;
    if (drop)         ovf_next = 1'b1;
    else if (clr_ovf) ovf_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_wr) w_ptr <= w_ptr + AWIDTH'(1);
      if (do_rd) r_ptr <= r_ptr + AWIDTH'(1);
      count_q <= count_next;
      empty_q <= empty_next;
      full_q  <= full_next;
      ovf_q   <= ovf_next;
    end
  end

  // Storage is not reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[w_ptr] <= w_data;
  end

  assign r_data   = mem[r_ptr];
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner
// sequences and a queue-based scoreboard for data ordering.
module tb_uart_rx_fifo;

  localparam int DBIT   = 8;
  localparam int AWIDTH = 4;
  localparam int DEPTH  = 1 << AWIDTH;

  logic              clk;
  logic              reset;
  logic              wr;
  logic [DBIT-1:0]   w_data;
  logic              rd;
  logic [DBIT-1:0]   r_data;
  logic              empty;
  logic              full;
  logic [AWIDTH:0]   count;
  logic              overflow;
  logic              clr_ovf;

  uart_rx_fifo #(.DBIT(DBIT), .AWIDTH(AWIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .w_data   (w_data),
    .rd       (rd),
    .r_data   (r_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [DBIT-1:0] exp_q[$];
  logic            model_ovf;
  int              n_checks;
  int              n_pass;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic check_state(input string tag);
    int occ;
    occ = exp_q.size();
    check({tag, ".count"},    int'(count),    occ);
    check({tag, ".empty"},    int'(empty),    int'(occ == 0));
    check({tag, ".full"},     int'(full),     int'(occ == DEPTH));
    check({tag, ".overflow"}, int'(overflow), int'(model_ovf));
    if (occ > 0) check({tag, ".head"}, int'(r_data), int'(exp_q[0]));
  endtask

  // ---------------- driver ----------------
  // One clock of stimulus: drive at the falling edge, check popped data
  // before the rising edge, update the model, then check state #1 after.
  task automatic step(input logic s_wr, input logic [DBIT-1:0] s_wd,
                      input logic s_rd, input logic s_clr, input string tag);
    int occ;
    bit w_ok, r_ok;
    @(negedge clk);
    wr = s_wr; w_data = s_wd; rd = s_rd; clr_ovf = s_clr;
    occ  = exp_q.size();
    r_ok = s_rd && (occ > 0);
    w_ok = s_wr && ((occ < DEPTH) || s_rd);
    if (r_ok) check({tag, ".pop"}, int'(r_data), int'(exp_q[0]));
    @(posedge clk);
    #1;
    if (r_ok) void'(exp_q.pop_front());
    if (w_ok) exp_q.push_back(s_wd);
    if (s_wr && !w_ok) model_ovf = 1'b1;
    else if (s_clr)    model_ovf = 1'b0;
    wr = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    model_ovf = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            wr;
    logic [DBIT-1:0] wd;
    logic            rd;
    logic            clr;
    int              cnt;
    logic            emp;
    logic            ful;
    logic            ovf;
    logic [DBIT-1:0] head;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  initial begin
    logic [DBIT-1:0] b;
    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[6] = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[7] = '{1'b1, 8'h33, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h22};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h33};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};

    n_checks = 0; n_pass = 0;
    wr = 1'b0; w_data = '0; rd = 1'b0; clr_ovf = 1'b0;
    reset = 1'b0;
    model_ovf = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset state
    #1;
    check("reset.empty", int'(empty), 1);
    check("reset.full", int'(full), 0);
    check("reset.count", int'(count), 0);
    check("reset.overflow", int'(overflow), 0);

    // Table: idle, empty-pop, empty wr+rd, basic push/pop
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tcount", i), int'(count), vecs[i].cnt);
      check($sformatf("vec%0d.tempty", i), int'(empty), int'(vecs[i].emp));
      check($sformatf("vec%0d.tfull", i), int'(full), int'(vecs[i].ful));
      check($sformatf("vec%0d.tovf", i), int'(overflow), int'(vecs[i].ovf));
      if (!vecs[i].emp) check($sformatf("vec%0d.thead", i), int'(r_data), int'(vecs[i].head));
    end

    // Fill with 0x00..0x0F, drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, DBIT'(i), 1'b0, 1'b0, "fill");
    check("fill.full", int'(full), 1);
    check("fill.count", int'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    check("drain.empty", int'(empty), 1);

    // Overflow: drop while full, clear/set collision, then clear
    for (int i = 0; i < DEPTH; i++) step(1'b1, DBIT'(i), 1'b0, 1'b0, "fill2");
    step(1'b1, 8'hAA, 1'b0, 1'b0, "drop");
    check("drop.overflow", int'(overflow), 1);
    check("drop.head", int'(r_data), 8'h00);
    check("drop.count", int'(count), DEPTH);
    step(1'b1, 8'hBB, 1'b0, 1'b1, "clr_vs_drop");
    check("clr_vs_drop.overflow", int'(overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr");
    check("clr.overflow", int'(overflow), 0);

    // Full with simultaneous push/pop
    step(1'b1, 8'h55, 1'b1, 1'b0, "full_both");
    check("full_both.count", int'(count), DEPTH);
    check("full_both.overflow", int'(overflow), 0);
    check("full_both.head", int'(r_data), 8'h01);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("full_both.last", int'(r_data), 8'h55);
      step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
    end

    // Wrap at occupancy 3
    for (int i = 0; i < 3; i++) step(1'b1, DBIT'($urandom_range(0, 255)), 1'b0, 1'b0, "wrap_pre");
    for (int i = 0; i < 37; i++) begin
      step(1'b1, DBIT'($urandom_range(0, 255)), 1'b1, 1'b0, "wrap");
      check("wrap.occ3", int'(count), 3);
    end

    // Asynchronous reset mid-stream, away from any clock edge
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst.empty", int'(empty), 1);
    check("async_rst.count", int'(count), 0);
    check("async_rst.full", int'(full), 0);
    exp_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 1'b0, "post_rst");
    check("post_rst.head", int'(r_data), 8'h5A);

    // Random mix
    do_reset();
    for (int i = 0; i < 300; i++) begin
      b = DBIT'($urandom_range(0, 255));
      step(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
